// File: rtl/seq_divider_if.sv
// Operand/result bundle for seq_divider (start/busy/done handshake plus data).
// The sign_mode signal exists only when SEQ_DIV_SIGNED_EN is defined.
interface seq_divider_if #(
    parameter int N_W = 16,
    parameter int D_W = 8
);
    logic           start;
    logic [D_W-1:0] A;
    logic [N_W-1:0] B;
`ifdef SEQ_DIV_SIGNED_EN
    logic           sign_mode;
`endif
    logic           busy;
    logic [N_W-1:0] Q;
    logic [D_W-1:0] R;
    logic           Done;
    logic           dz;

`ifdef SEQ_DIV_SIGNED_EN
    modport master (output start, A, B, sign_mode, input  busy, Q, R, Done, dz);
    modport slave  (input  start, A, B, sign_mode, output busy, Q, R, Done, dz);
`else
    modport master (output start, A, B, input  busy, Q, R, Done, dz);
    modport slave  (input  start, A, B, output busy, Q, R, Done, dz);
`endif
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, with divide-by-zero flag.
// Define SEQ_DIV_SIGNED_EN to add the sign_mode input and the FIX sign-correction state.
//
// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// RUN   | one restoring step per cycle while the counter is non-zero
// FIX   | apply quotient/remainder signs (signed build, sign_mode=1)
// DONE  | Done pulse; results are already loaded
module seq_divider #(
    parameter int N_W = 16,
    parameter int D_W = 8
) (
    input  logic         clk,
    input  logic         clear,
    seq_divider_if.slave bus
);
    localparam int            CW       = $clog2(N_W + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(N_W);

`ifdef SEQ_DIV_SIGNED_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd3
    } state_t;
`endif

    state_t         r_state;
    state_t         w_state_next;
    logic [CW-1:0]  r_cnt;
    logic [D_W-1:0] r_p;
    logic [D_W-1:0] r_dvs;
    logic [D_W-1:0] r_b_lo;
    logic [D_W-1:0] r_r;
    logic [N_W-1:0] r_dvd;
    logic [N_W-1:0] r_q;
    logic           r_zero;
    logic           r_dz;
`ifdef SEQ_DIV_SIGNED_EN
    logic           r_sgn;
    logic           r_neg_q;
    logic           r_neg_r;
    logic           w_b_neg;
    logic           w_a_neg;
    logic           w_go_fix;
`endif

    logic [D_W:0]   w_p_shift;
    logic           w_ge;
    logic [D_W-1:0] w_p_next;
    logic [N_W-1:0] w_dvd_next;
    logic           w_cnt_zero;
    logic           w_first;

    // The remainder never exceeds the divisor, so the subtraction fits in D_W bits.
    assign w_p_shift  = {r_p, r_dvd[N_W-1]};
    assign w_ge       = (w_p_shift >= {1'b0, r_dvs});
    assign w_p_next   = w_ge ? (w_p_shift[D_W-1:0] - r_dvs) : w_p_shift[D_W-1:0];
    assign w_dvd_next = {r_dvd[N_W-2:0], w_ge};
    assign w_cnt_zero = (r_cnt == '0);
    assign w_first    = (r_cnt == CNT_INIT);

`ifdef SEQ_DIV_SIGNED_EN
    assign w_b_neg  = bus.sign_mode & bus.B[N_W-1];
    assign w_a_neg  = bus.sign_mode & bus.A[D_W-1];
    assign w_go_fix = r_sgn & ~r_zero;
`endif

    always_ff @(posedge clk) begin
        if (clear) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_cnt_zero) begin
`ifdef SEQ_DIV_SIGNED_EN
                    w_state_next = w_go_fix ? S_FIX : S_DONE;
`else
                    w_state_next = S_DONE;
`endif
                end
            end
`ifdef SEQ_DIV_SIGNED_EN
            S_FIX: begin
                w_state_next = S_DONE;
            end
`endif
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            r_cnt   <= '0;
            r_p     <= '0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_b_lo  <= '0;
            r_zero  <= 1'b0;
            r_q     <= '0;
            r_r     <= '0;
            r_dz    <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
            r_sgn   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_cnt  <= CNT_INIT;
                        r_p    <= '0;
                        r_zero <= 1'b0;
                        r_b_lo <= bus.B[D_W-1:0];
`ifdef SEQ_DIV_SIGNED_EN
                        // Magnitudes are divided; the most-negative value keeps its bit
                        // pattern, which is already its unsigned magnitude.
                        r_sgn   <= bus.sign_mode;
                        r_neg_q <= w_b_neg ^ w_a_neg;
                        r_neg_r <= w_b_neg;
                        r_dvd   <= w_b_neg ? -bus.B : bus.B;
                        r_dvs   <= w_a_neg ? -bus.A : bus.A;
`else
                        r_dvd   <= bus.B;
                        r_dvs   <= bus.A;
`endif
                    end
                end
                S_RUN: begin
                    if (w_first && (r_dvs == '0)) begin
                        // Skip every step; the cnt==0 cycle then finishes the operation.
                        r_zero <= 1'b1;
                        r_cnt  <= '0;
                    end else if (!w_cnt_zero) begin
                        r_p   <= w_p_next;
                        r_dvd <= w_dvd_next;
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
`ifdef SEQ_DIV_SIGNED_EN
                        if (!w_go_fix) begin
`else
                        begin
`endif
                            if (r_zero) begin
                                r_q  <= '1;
                                r_r  <= r_b_lo;
                                r_dz <= 1'b1;
                            end else begin
                                r_q  <= r_dvd;
                                r_r  <= r_p;
                                r_dz <= 1'b0;
                            end
                        end
                    end
                end
`ifdef SEQ_DIV_SIGNED_EN
                S_FIX: begin
                    r_q  <= r_neg_q ? -r_dvd : r_dvd;
                    r_r  <= r_neg_r ? -r_p : r_p;
                    r_dz <= 1'b0;
                end
`endif
                default: begin
                end
            endcase
        end
    end

    assign bus.busy = (r_state != S_IDLE);
    assign bus.Done = (r_state == S_DONE);
    assign bus.Q    = r_q;
    assign bus.R    = r_r;
    assign bus.dz   = r_dz;
endmodule
